// File: rtl/lenet_scheduler.sv
// lenet_scheduler: turns data_ready edges from the downsampler into single
// inference requests for the LeNet engine. It watches each request for a
// timeout and majority-free voting: the displayed digit only changes after
// VOTE_DEPTH consecutive identical results.
module lenet_scheduler #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int VOTE_DEPTH     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       data_ready,
    input  logic       lenet_ready,
    input  logic [3:0] lenet_digit,
    output logic       lenet_go,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] drop_count
);

    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    FULL     = 4'(VOTE_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_GO, S_WAIT, S_LATCH, S_ABORT} state_t;

    state_t          state_q, state_d;
    logic            prev_q, arm_q, pending_q;
    logic [7:0]      drop_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      result_q, result_d;
    logic [3:0]      fill_q, fill_d;
    logic [3:0]      dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            terr_q, terr_d;
    logic            hist_shift;
    logic [3:0]      hist_q [VOTE_DEPTH];
    logic [VOTE_DEPTH-1:0] match;

    // arm_q masks the first cycle after reset so a level already high is not an edge
    logic rise, consume, result_ok, all_match;
    assign rise      = data_ready & ~prev_q & arm_q;
    assign consume   = (state_q == S_GO);
    assign result_ok = (result_q < 4'd10);
    assign all_match = &match;

    // After a shift, entry 0 is the new result; the rest must already equal it
    genvar gi;
    generate
        for (gi = 0; gi < VOTE_DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign match[gi] = 1'b1;
                // newest result enters the head of the history
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)          hist_q[gi] <= 4'd0;
                    else if (hist_shift) hist_q[gi] <= result_q;
                end
            end else begin : g_tail
                assign match[gi] = (hist_q[gi-1] == result_q);
                // older results move one slot down the history
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)          hist_q[gi] <= 4'd0;
                    else if (hist_shift) hist_q[gi] <= hist_q[gi-1];
                end
            end
        end
    endgenerate

    // Edge detector, one-deep pending slot and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 1'b0;
            arm_q     <= 1'b0;
            pending_q <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            prev_q <= data_ready;
            arm_q  <= 1'b1;
            if (rise) begin
                pending_q <= 1'b1;
                if (pending_q && !consume && drop_q != 8'hFF)
                    drop_q <= drop_q + 8'd1;
            end else if (consume) begin
                pending_q <= 1'b0;
            end
        end
    end

    // FSM and datapath state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= 4'd0;
            fill_q   <= 4'd0;
            dout_q   <= 4'd0;
            valid_q  <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            fill_q   <= fill_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            terr_q   <= terr_d;
        end
    end

    // Next-state logic: launch, wait with timeout, vote on result, or abort
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        fill_d     = fill_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        terr_d     = terr_q;
        hist_shift = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q && enable) state_d = S_GO;
            end
            S_GO: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // a result arriving on the last allowed cycle still wins
                if (lenet_ready) begin
                    result_d = lenet_digit;
                    state_d  = S_LATCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ABORT;
                end
            end
            S_LATCH: begin
                state_d = S_IDLE;
                if (result_ok) begin
                    hist_shift = 1'b1;
                    terr_d     = 1'b0;
                    fill_d     = (fill_q >= FULL) ? FULL : fill_q + 4'd1;
                    if (fill_d == FULL && all_match) begin
                        dout_d  = result_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    fill_d = 4'd0;
                end
            end
            S_ABORT: begin
                terr_d  = 1'b1;
                fill_d  = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign lenet_go    = (state_q == S_GO);
    assign busy        = (state_q != S_IDLE);
    assign digit_out   = dout_q;
    assign digit_valid = valid_q;
    assign timeout_err = terr_q;
    assign drop_count  = drop_q;

endmodule

// File: doc/lenet_scheduler.md
LENET_SCHEDULER -- requirements
Module: lenet_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning max clk cycles from lenet_go until lenet_ready before abort.
REQ-002 SHALL have parameter VOTE_DEPTH, default 3, range 1..8, meaning consecutive identical results required to update the displayed digit.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge; one clock, reset asynchronous active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  level; high permits new inferences (switch-driven, already synchronous to clk).
REQ-006 SHALL have port data_ready  input  1  level from downsampler; a rising edge means the 28x28 input buffer holds a new frame.
REQ-007 SHALL have port lenet_ready  input  1  one-cycle done pulse from the inference engine.
REQ-008 SHALL have port lenet_digit  input  4  engine result, valid in the lenet_ready cycle.
REQ-009 SHALL have port lenet_go  output  1  one-cycle start pulse to the engine.
REQ-010 SHALL have port digit_out  output  4  voted digit for display.
REQ-011 SHALL have port digit_valid  output  1  high once digit_out holds a voted result.
REQ-012 SHALL have port busy  output  1  high from lenet_go until result or abort.
REQ-013 SHALL have port timeout_err  output  1  sticky abort flag.
REQ-014 SHALL have port drop_count  output  8  frames dropped while pending slot full, saturating.

Function
REQ-015 SHALL detect the data_ready rising edge with a registered previous value; an edge sets a one-deep pending flag.
REQ-016 SHALL, on an edge while pending is already set, keep pending set and increment drop_count, saturating at 255.
REQ-017 SHALL implement FSM states IDLE, GO, WAIT, LATCH, ABORT.
REQ-018 IDLE->GO when pending and enable; in GO, lenet_go=1 for exactly one cycle, pending clears, and the timeout counter loads 0; GO->WAIT next cycle.
REQ-019 SHALL, in WAIT, increment the timeout counter each cycle; lenet_ready=1 -> LATCH; counter==TIMEOUT_CYCLES-1 without lenet_ready -> ABORT.
REQ-020 SHALL give lenet_ready priority over timeout when both occur in the same cycle.
REQ-021 SHALL, in LATCH (one cycle), capture lenet_digit; digits 0..9 shift into a VOTE_DEPTH-entry history, and digits 10..15 are discarded and clear the history fill count; LATCH->IDLE.
REQ-022 SHALL update digit_out and set digit_valid one cycle after LATCH when history is full and all entries are equal; otherwise digit_out holds.
REQ-023 SHALL, in ABORT (one cycle), set timeout_err, clear history fill count, and go ABORT->IDLE; timeout_err clears only on the next accepted LATCH with digit 0..9.
REQ-024 SHALL ignore lenet_ready outside WAIT.
REQ-025 busy SHALL be 1 in GO, WAIT, LATCH, ABORT and 0 in IDLE.
REQ-026 SHALL let the current inference run to completion when enable drops mid-operation, and start no new one; pending is retained.
REQ-027 With VOTE_DEPTH=1, every valid result SHALL update digit_out.
REQ-028 Latency: data_ready edge in IDLE -> lenet_go asserted 2 cycles later (edge register, then GO).

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force state=IDLE, lenet_go=0, busy=0, digit_out=0, digit_valid=0, timeout_err=0, drop_count=0, pending=0, history fill=0, timeout counter=0, and previous data_ready=0.
REQ-030 SHALL cause no lenet_go pulse on the first cycle after reset release, even if data_ready is already high; only a subsequent 0->1 edge counts.

Verification
REQ-031 enable=1, VOTE_DEPTH=3, three frames each answered by lenet_ready with digit 7 -> exactly three lenet_go pulses; digit_valid rises after the third LATCH; digit_out=7.
REQ-032 results 7,7,3 -> digit_out unchanged, digit_valid stays 0; then 3,3 -> digit_out=3.
REQ-033 TIMEOUT_CYCLES=16, no lenet_ready -> ABORT 16 cycles after GO; timeout_err=1, busy=0; next valid result clears timeout_err.
REQ-034 three data_ready edges during a single WAIT -> drop_count=2; exactly one further lenet_go after LATCH.
REQ-035 rst_n pulsed low during WAIT -> all outputs at reset values immediately; a late lenet_ready after release is ignored; lenet_digit=12 -> history cleared, digit_out held.
